// File: rtl/mod_reducer_if.sv
// Start/done handshake bundle between a requester and the mod_reducer divider.
// The requester drives the operands; the divider returns status and held results.
interface mod_reducer_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] m;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, a, m,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, a, m,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/mod_reducer.sv
// Restoring shift-subtract unsigned divider: one quotient bit per clock,
// reporting a / m and a mod m through a start/done handshake.
module mod_reducer #(
    parameter int N = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mod_reducer_if.slave  bus
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q;
    logic [N-1:0]  aSh_q;
    logic [N-1:0]  divisor_q;
    logic [N-1:0]  partRem_q;
    logic [N-1:0]  quoSh_q;
    logic [CW-1:0] count_q;
    logic          busy_q;
    logic          done_q;
    logic [N-1:0]  quotient_q;
    logic [N-1:0]  remainder_q;
    logic          dbz_q;

    logic [N:0]    shifted_d;
    logic [N+1:0]  trial_d;
    logic          quoBit_d;
    logic [N-1:0]  nextRem_d;
    logic [N-1:0]  nextQuo_d;

    // The trial difference is two bits wider than the divisor so that a shifted
    // remainder of up to 2m-1 never wraps, even when m has its MSB set; a
    // non-negative result always fits in N bits, so the remainder keeps N bits.
    always_comb begin
        shifted_d = {partRem_q, aSh_q[N-1]};
        trial_d   = {1'b0, shifted_d} - {2'b00, divisor_q};
        quoBit_d  = (trial_d[N+1:N] == 2'b00);
        nextRem_d = quoBit_d ? trial_d[N-1:0] : shifted_d[N-1:0];
        nextQuo_d = {quoSh_q[N-2:0], quoBit_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            aSh_q       <= '0;
            divisor_q   <= '0;
            partRem_q   <= '0;
            quoSh_q     <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        aSh_q     <= bus.a;
                        divisor_q <= bus.m;
                        partRem_q <= '0;
                        quoSh_q   <= '0;
                        count_q   <= CW'(N - 1);
                        // Zero divisor follows the RISC-V divu/remu convention.
                        if (bus.m == '0) begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= bus.a;
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    partRem_q <= nextRem_d;
                    quoSh_q   <= nextQuo_d;
                    aSh_q     <= aSh_q << 1;
                    count_q   <= count_q - CW'(1);
                    if (count_q == '0) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= nextQuo_d;
                        remainder_q <= nextRem_d;
                        dbz_q       <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule
